// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and bank-state type for the scan-out/writer scheduler.
package fb_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_PIXELS = FB_W * FB_H;
    localparam int FB_AW     = 17;
    localparam int PIX_W     = 8;

    typedef enum logic {
        FILL      = 1'b0,
        SWAP_WAIT = 1'b1
    } fb_bank_state_t;

endpackage

// File: rtl/fb_port_scheduler_scan.sv
// Scan-out pixel index: synchronous clear, advance while enabled, wrap at the end of the frame.
module fb_scan_counter
    import fb_pkg::*;
#(
    parameter int DEPTH = FB_PIXELS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [FB_AW-1:0] o_idx
);

    logic [FB_AW-1:0] r_idx;

    // Clear has priority so a frame start coinciding with an active pixel restarts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= (r_idx == FB_AW'(DEPTH - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/fb_port_scheduler.sv
// Single-port framebuffer arbiter: VGA scan-out reads win, writer is served in blank cycles.
// Define FB_DOUBLE_BUFFER_EN for front/back banks that swap only at frame_rst.
module fb_port_scheduler #(
    parameter int PIX_W = 8,
    parameter int FB_W  = 320,
    parameter int FB_H  = 240
) (
    input  logic             bit_clk,
    input  logic             rst,
    input  logic             vga_blank,
    input  logic             frame_rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [16:0]      wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             wr_frame_done,
    output logic             swap_ack,
    output logic             wr_err,
    output logic [17:0]      mem_addr,
    output logic             mem_we,
    output logic [PIX_W-1:0] mem_wdata,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid
);
    import fb_pkg::*;

    localparam int NPIX = FB_W * FB_H;

    logic [FB_AW-1:0] w_scan_idx;
    logic             w_rd_bank;
    logic             w_wr_bank;
    logic             w_in_range;
    logic             w_accept;
    logic             r_wr_err;
    logic             r_blank_d1;
    logic             r_pix_valid;
    logic [PIX_W-1:0] r_pix_data;

    fb_scan_counter #(
        .DEPTH(NPIX)
    ) u_scan (
        .clk  (bit_clk),
        .rst  (rst),
        .i_clr(frame_rst),
        .i_en (vga_blank),
        .o_idx(w_scan_idx)
    );

    assign w_in_range = (wr_addr < FB_AW'(NPIX));
    assign w_accept   = wr_valid & wr_ready;

`ifdef FB_DOUBLE_BUFFER_EN
    fb_bank_state_t r_state;
    fb_bank_state_t w_state_next;
    logic           r_front;
    logic           w_front_next;
    logic           r_swap_ack;
    logic           w_swap_ack_next;

    always_ff @(posedge bit_clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_front    <= 1'b0;
            r_swap_ack <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_front    <= w_front_next;
            r_swap_ack <= w_swap_ack_next;
        end
    end

    // A frame_done landing on frame_rst swaps at once instead of waiting a whole frame.
    always_comb begin
        w_state_next    = r_state;
        w_front_next    = r_front;
        w_swap_ack_next = 1'b0;
        case (r_state)
            FILL: begin
                if (wr_frame_done) begin
                    if (frame_rst) begin
                        w_front_next    = ~r_front;
                        w_swap_ack_next = 1'b1;
                    end else begin
                        w_state_next = SWAP_WAIT;
                    end
                end
            end
            SWAP_WAIT: begin
                if (frame_rst) begin
                    w_front_next    = ~r_front;
                    w_swap_ack_next = 1'b1;
                    w_state_next    = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    assign wr_ready  = ~vga_blank & (r_state == FILL);
    assign swap_ack  = r_swap_ack;
    assign w_rd_bank = r_front;
    assign w_wr_bank = ~r_front;
`else
    logic w_unused_frame_done;
    assign w_unused_frame_done = wr_frame_done;

    assign wr_ready  = ~vga_blank;
    assign swap_ack  = 1'b0;
    assign w_rd_bank = 1'b0;
    assign w_wr_bank = 1'b0;
`endif

    always_comb begin
        mem_addr  = {w_wr_bank, wr_addr};
        mem_we    = w_accept & w_in_range;
        mem_wdata = wr_data;
        if (vga_blank) begin
            mem_addr = {w_rd_bank, w_scan_idx};
            mem_we   = 1'b0;
        end
    end

    // Two-stage pixel path: RAM read latency plus the output register.
    always_ff @(posedge bit_clk or posedge rst) begin
        if (rst) begin
            r_wr_err    <= 1'b0;
            r_blank_d1  <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
        end else begin
            r_wr_err    <= w_accept & ~w_in_range;
            r_blank_d1  <= vga_blank;
            r_pix_valid <= r_blank_d1;
            r_pix_data  <= mem_rdata;
        end
    end

    assign wr_err    = r_wr_err;
    assign pix_valid = r_pix_valid;
    assign pix_data  = r_pix_data;

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Self-checking bench for fb_port_scheduler: directed scenarios plus random traffic vs a frame-level model.
module tb_fb_port_scheduler;

    localparam int NPIX  = 76800;
    localparam int MSIZE = 262144;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        bit_clk       = 1'b0;
    logic        rst           = 1'b1;
    logic        vga_blank     = 1'b0;
    logic        frame_rst     = 1'b0;
    logic        wr_valid      = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic [16:0] wr_addr       = '0;
    logic [7:0]  wr_data       = '0;
    logic        wr_ready, swap_ack, wr_err, mem_we, pix_valid;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, pix_data;

    logic [7:0]  ram       [0:MSIZE-1];
    logic [7:0]  model_mem [0:MSIZE-1];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: scan position, displayed bank, waiting-for-swap flag, output pipeline.
    int          m_scan  = 0;
    bit          m_front = 0, m_wait = 0, m_swap = 0, m_err = 0, m_pv = 0, m_bd1 = 0;
    logic [7:0]  m_pix   = '0;
    logic [7:0]  m_rd    = '0;

    always #5 bit_clk = ~bit_clk;

    fb_port_scheduler dut (
        .bit_clk      (bit_clk),
        .rst          (rst),
        .vga_blank    (vga_blank),
        .frame_rst    (frame_rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_frame_done(wr_frame_done),
        .swap_ack     (swap_ack),
        .wr_err       (wr_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid)
    );

    // Framebuffer RAM seen by the DUT: one-cycle read latency, read-before-write.
    always @(posedge bit_clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    function automatic logic [7:0] pat(input int i);
        logic [7:0] v;
        v = 8'(i);
        if (i >= 131072) v = v ^ 8'h5A;
        return v;
    endfunction

    function automatic bit f_ready();
        return !vga_blank && !(DBL && m_wait);
    endfunction

    function automatic logic [17:0] f_addr();
        logic [16:0] s;
        s = 17'(m_scan);
        if (vga_blank) return {DBL & m_front, s};
        return {DBL & ~m_front, wr_addr};
    endfunction

    function automatic bit f_we();
        return f_ready() && wr_valid && (int'(wr_addr) < NPIX);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_front = 0; m_wait = 0; m_swap = 0; m_err = 0;
        m_pv = 0; m_bd1 = 0; m_pix = '0;
    endtask

    // Advance the model by one clock using the inputs that the next rising edge will sample.
    task automatic model_step();
        logic [17:0] a;
        a     = f_addr();
        m_pix = m_rd;
        m_rd  = model_mem[a];
        if (f_we()) model_mem[a] = wr_data;
        m_pv  = m_bd1;
        m_bd1 = vga_blank;
        m_err = wr_valid && f_ready() && (int'(wr_addr) >= NPIX);
        m_swap = 1'b0;
        if (DBL) begin
            if (!m_wait && wr_frame_done && !frame_rst) begin
                m_wait = 1'b1;
            end else if ((m_wait || wr_frame_done) && frame_rst) begin
                m_front = !m_front;
                m_swap  = 1'b1;
                m_wait  = 1'b0;
            end
        end
        if (frame_rst) m_scan = 0;
        else if (vga_blank) m_scan = (m_scan + 1) % NPIX;
    endtask

    // Per-cycle compare: inputs change on the falling edge, outputs are checked 2 time units later.
    always @(negedge bit_clk) begin
        #2;
        if (rst) model_reset();
        check("wr_ready", 32'(wr_ready), 32'(f_ready()));
        check("mem_addr", 32'(mem_addr), 32'(f_addr()));
        check("mem_we", 32'(mem_we), 32'(f_we()));
        if (f_we()) check("mem_wdata", 32'(mem_wdata), 32'(wr_data));
        check("swap_ack", 32'(swap_ack), 32'(m_swap));
        check("wr_err", 32'(wr_err), 32'(m_err));
        check("pix_valid", 32'(pix_valid), 32'(m_pv));
        if (m_pv) check("pix_data", 32'(pix_data), 32'(m_pix));
        if (!rst) model_step();
    end

    task automatic drive(input logic b, input logic fr, input logic v,
                         input logic [16:0] a, input logic [7:0] d, input logic fd);
        @(negedge bit_clk);
        vga_blank = b; frame_rst = fr; wr_valid = v;
        wr_addr = a; wr_data = d; wr_frame_done = fd;
        #3;
    endtask

    task automatic set_rst(input logic v);
        @(negedge bit_clk);
        rst = v;
        #3;
    endtask

    initial begin
        bit          pend;
        logic [16:0] paddr;
        logic [7:0]  pdata;
        for (int i = 0; i < MSIZE; i++) begin
            ram[i]       = pat(i);
            model_mem[i] = pat(i);
        end

        repeat (2) drive(0, 0, 0, 17'd0, 8'd0, 0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_swap_ack", 32'(swap_ack), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        set_rst(1'b0);
        $display("reset released at %0t", $time);

        drive(0, 1, 0, 17'd0, 8'd0, 0);
        for (int k = 0; k < 8; k++) begin
            drive(k < 5, 0, 0, 17'd0, 8'd0, 0);
            if (k < 5) check("scan_addr", 32'(mem_addr), 32'(k));
            if (k >= 2 && k < 7) begin
                check("scan_pix_valid", 32'(pix_valid), 32'd1);
                check("scan_pix_data", 32'(pix_data), 32'(k - 2));
            end
            if (k == 7) check("scan_pix_valid_end", 32'(pix_valid), 32'd0);
        end
        $display("scan-out of 5 pixels done at %0t", $time);

        repeat (3) begin
            drive(1, 0, 1, 17'd100, 8'hA5, 0);
            check("blank_wr_ready", 32'(wr_ready), 32'd0);
            check("blank_mem_we", 32'(mem_we), 32'd0);
        end
        drive(0, 0, 1, 17'd100, 8'hA5, 0);
        check("wr_ready_after_blank", 32'(wr_ready), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", 32'(mem_addr), DBL ? 32'h20064 : 32'h00064);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
        drive(0, 0, 0, 17'd0, 8'd0, 0);
        $display("write addr=100 data=a5 done at %0t", $time);

        drive(0, 0, 0, 17'd0, 8'd0, 1);
        check("fdone_wr_ready", 32'(wr_ready), 32'd1);
        repeat (10) begin
            drive(0, 0, 1, 17'd200, 8'h3C, 0);
            check("swapwait_wr_ready", 32'(wr_ready), 32'(!DBL));
        end
        drive(0, 1, 0, 17'd0, 8'd0, 0);
        drive(1, 0, 0, 17'd0, 8'd0, 0);
        check("swap_ack_pulse", 32'(swap_ack), 32'(DBL));
        check("swap_first_read", 32'(mem_addr), DBL ? 32'h20000 : 32'h00000);
        drive(0, 0, 0, 17'd0, 8'd0, 0);
        check("swap_ack_low", 32'(swap_ack), 32'd0);
        $display("deferred swap done at %0t", $time);

        drive(0, 1, 0, 17'd0, 8'd0, 1);
        drive(1, 0, 0, 17'd0, 8'd0, 0);
        check("imm_swap_ack", 32'(swap_ack), 32'(DBL));
        check("imm_swap_read", 32'(mem_addr), 32'h00000);
        drive(0, 0, 0, 17'd0, 8'd0, 0);
        check("imm_swap_fill", 32'(wr_ready), 32'd1);
        check("imm_swap_ack_low", 32'(swap_ack), 32'd0);
        $display("immediate swap done at %0t", $time);

        drive(0, 0, 1, 17'd76800, 8'h77, 0);
        check("oor_wr_ready", 32'(wr_ready), 32'd1);
        check("oor_mem_we", 32'(mem_we), 32'd0);
        drive(0, 0, 0, 17'd0, 8'd0, 0);
        check("oor_wr_err", 32'(wr_err), 32'd1);
        drive(0, 0, 0, 17'd0, 8'd0, 0);
        check("oor_wr_err_low", 32'(wr_err), 32'd0);
        $display("out-of-range write addr=76800 done at %0t", $time);

        pend = 0; paddr = '0; pdata = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend  = 1;
                paddr = ($urandom_range(0, 9) == 0) ? 17'($urandom_range(76800, 131071))
                                                    : 17'($urandom_range(0, 63));
                pdata = 8'($urandom);
            end
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, pend,
                  paddr, pdata, $urandom_range(0, 49) == 0);
            if (pend && wr_ready) pend = 0;
        end
        $display("random traffic of 3000 cycles done at %0t", $time);

        drive(0, 1, 0, 17'd0, 8'd0, 0);
        for (int j = 0; j <= NPIX; j++) begin
            drive(1, 0, 0, 17'd0, 8'd0, 0);
            if (j == NPIX - 1) check("scan_last", 32'(mem_addr[16:0]), 32'd76799);
            if (j == NPIX) check("scan_wrap", 32'(mem_addr[16:0]), 32'd0);
        end
        $display("full-frame scan wrap done at %0t", $time);

        set_rst(1'b1);
        check("midrst_pix_valid", 32'(pix_valid), 32'd0);
        check("midrst_pix_data", 32'(pix_data), 32'd0);
        check("midrst_swap_ack", 32'(swap_ack), 32'd0);
        check("midrst_wr_err", 32'(wr_err), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) drive(0, 0, 0, 17'd0, 8'd0, 0);
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);
        set_rst(1'b0);
        drive(0, 1, 0, 17'd0, 8'd0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 17'd0, 8'd0, 0);
            check("resume_addr", 32'(mem_addr), 32'(k));
        end
        repeat (3) drive(0, 0, 0, 17'd0, 8'd0, 0);
        $display("mid-line reset and resume done at %0t", $time);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_port_scheduler.md
# fb_port_scheduler

Schedules the single-port framebuffer RAM between two users: VGA scan-out reads and accelerator result writes. Scan-out is driven by the VGA timing block's `vga_blank` (high in the 320x240 visible window) and `frame_rst` outputs and always has priority. The writer is served through a valid/ready handshake in all other cycles. With double buffering compiled in, the writer fills a back bank, and banks swap only at a frame boundary so the display never tears.

## Interface
Parameters:
- `PIX_W`, 8: pixel width in bits.
- `FB_W`, 320: visible width in pixels.
- `FB_H`, 240: visible height in pixels.

Ports:
- `bit_clk` in 1: pixel clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `vga_blank` in 1: display enable from timing block; high means a pixel is needed this cycle.
- `frame_rst` in 1: one-cycle pulse before the visible window.
- `wr_valid` in 1: writer request.
- `wr_ready` out 1: request accepted this cycle.
- `wr_addr` in 17: pixel index, y*FB_W+x.
- `wr_data` in PIX_W: write data.
- `wr_frame_done` in 1: pulse; the back bank is complete.
- `swap_ack` out 1: pulse; the swap took effect.
- `wr_err` out 1: pulse; the accepted write was out of range and dropped.
- `mem_addr` out 18: `{bank, index}` to RAM.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out PIX_W: RAM write data.
- `mem_rdata` in PIX_W: RAM read data, 1-cycle latency.
- `pix_data` out PIX_W: display pixel.
- `pix_valid` out 1: `pix_data` qualifier.

## Operation
- Scan counter `scan_idx` (17b):
  - Cleared on `frame_rst`.
  - Otherwise +1 in every cycle with `vga_blank`=1.
  - Wraps from FB_W*FB_H-1 to 0.
  - `frame_rst` wins if it coincides with `vga_blank`.
- Port mux (combinational from registers and inputs):
  - `vga_blank`=1: `mem_addr={front,scan_idx}`, `mem_we`=0.
  - Otherwise: `mem_addr={~front,wr_addr}`, `mem_we=wr_valid&wr_ready&(wr_addr<FB_W*FB_H)`, `mem_wdata=wr_data`.
- `wr_ready = ~vga_blank & (state==FILL)`.
- An accepted write with `wr_addr>=76800` is dropped: `mem_we`=0, and `wr_err` pulses on the next cycle.
- Bank state machine:
  - FILL: writes accepted. `wr_frame_done` goes to SWAP_WAIT.
  - SWAP_WAIT: `wr_ready`=0. On `frame_rst`, `front` toggles, `swap_ack` pulses, and the state returns to FILL.
  - `wr_frame_done` coinciding with `frame_rst` while in FILL swaps in that same cycle.
  - `wr_frame_done` in SWAP_WAIT is ignored.
- Pixel path: `mem_rdata` is registered into `pix_data`. `pix_valid` is `vga_blank` delayed 2 cycles.

## Timing
- Reset values:
  - `front`=0, state=FILL, `scan_idx`=0.
  - `pix_data`=0, `pix_valid`=0, `swap_ack`=0, `wr_err`=0.
  - `wr_ready` follows its equation (1 if `vga_blank`=0).
- Pixel latency: `vga_blank` in cycle N gives `pix_valid`/`pix_data` in cycle N+2. The top level delays sync signals to match.
- Handshake:
  - A transfer happens in a cycle with `wr_valid&wr_ready`.
  - The writer holds addr/data stable until accepted.
  - The write lands in the same cycle (RAM samples on the clock edge).
- Swap: `front` changes on the edge that samples `frame_rst`. `swap_ack` is high the following cycle. The first display read after the swap uses the new bank.
- Reset mid-frame: all state clears immediately. The display resumes from index 0 at the next `frame_rst`.

## Configuration
- `FB_DOUBLE_BUFFER_EN` defined: behaviour as above, with two banks and `mem_addr[17]` as the bank bit.
- Undefined:
  - Single bank; `mem_addr[17]` is tied 0.
  - No state machine; `wr_ready=~vga_blank`.
  - `wr_frame_done` is ignored, `swap_ack` is tied 0.
  - Tearing is accepted.

## Structure
- Shared package `fb_pkg`:
  - `FB_W`, `FB_H`, `FB_PIXELS` (76800), `FB_AW` (17), `PIX_W`.
  - `fb_bank_state_t` enum (FILL, SWAP_WAIT).
- Sub-module `fb_scan_counter`: `scan_idx` with clear, enable and wrap. It is reused by any future scan-side prefetch.

## Test plan
- Reset, then `frame_rst`, then 5 cycles `vga_blank`=1 with `mem_rdata`=idx. Expect `mem_addr`=0..4 on bank 0, and `pix_data`=0..4 with `pix_valid` 2 cycles later.
- `wr_valid` held with `wr_addr`=100, `wr_data`=0xA5 while `vga_blank`=1 for 3 cycles. Expect `wr_ready`=0 throughout; the write (`mem_addr`=0x20064, `mem_we`=1) happens in the first cycle after blank falls.
- `wr_frame_done` pulse, then `frame_rst` 10 cycles later. Expect `wr_ready`=0 in between, `front` 0→1, `swap_ack` 1 cycle after `frame_rst`, and the next display read at bank 1 (`mem_addr`=0x20000).
- `wr_frame_done` coincident with `frame_rst`. Expect an immediate swap, `swap_ack` next cycle, and the state stays FILL.
- `wr_addr`=76800 accepted. Expect `mem_we`=0 and `wr_err`=1 for one cycle.
- 76800 `vga_blank` cycles with no `frame_rst`. Expect `scan_idx` to wrap to 0 on cycle 76801. Then assert `rst` mid-line and expect all outputs at their reset values immediately.
